// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maze_pkg
// Purpose  : Constants shared by the maze game controller and the mover.
//            Holds the game state encodings, the respawn coordinates and the
//            default timing and lives parameters.
// Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

  // Game state encodings. They are visible on the controller's state port.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PLAY = 3'd1;
  localparam logic [2:0] DEAD = 3'd2;
  localparam logic [2:0] OVER = 3'd3;
  localparam logic [2:0] WIN  = 3'd4;

  // The mover loads this position when it sees respawn.
  localparam int START_X = 55;
  localparam int START_Y = 55;

  // Default game parameters.
  localparam int FRAMES_PER_SEC_DEF = 60;
  localparam int LIVES_INIT_DEF     = 3;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Purpose  : Two-flop synchronizer for an active-low push button. It gives a
//            one-cycle pulse on each registered high-to-low edge.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [1:0] r_fill;

  // Synchronize the button, delay it once more for edge detection, and count
  // the edges since reset until the delay line holds only real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_sync3 <= RESET_VAL;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  // Report an edge only after a real released sample has been seen. This way
  // a button held through reset release does not produce a press.
  assign press = (r_fill == 2'd3) & r_sync3 & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maze_game_ctrl
// Purpose  : Game-flow FSM for the VGA maze. It moves through attract, play,
//            death flash, game over and win. It owns lives, elapsed seconds,
//            flash and the respawn request.
// Revision : 1.0 - initial release
// ============================================================================
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int LIVES_INIT     = LIVES_INIT_DEF,
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int DEAD_FRAMES    = 60,
  parameter int FLASH_FRAMES   = 8,
  parameter int TIME_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start_n,
  input  logic              hit,
  input  logic              goal,
  output logic [2:0]        state,
  output logic              move_en,
  output logic              respawn,
  output logic [1:0]        lives,
  output logic [TIME_W-1:0] time_sec,
  output logic              flash
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
  localparam int LW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [FW-1:0]     c_FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [DW-1:0]     c_DEAD_LAST  = DW'(DEAD_FRAMES - 1);
  localparam logic [LW-1:0]     c_FLASH_LAST = LW'(FLASH_FRAMES - 1);
  localparam logic [TIME_W-1:0] c_TIME_MAX   = '1;
  localparam logic [1:0]        c_LIVES      = 2'(LIVES_INIT);

  logic              w_press;
  logic [2:0]        r_state;
  logic              r_move_en;
  logic              r_respawn;
  logic [1:0]        r_lives;
  logic [TIME_W-1:0] r_time;
  logic              r_flash;
  logic [FW-1:0]     r_frame_cnt;
  logic [DW-1:0]     r_dead_cnt;
  logic [LW-1:0]     r_flash_cnt;

  btn_sync_edge #(
    .RESET_VAL (1'b1)
  ) u_start_sync (
    .clk   (clk),
    .reset (reset),
    .btn_n (start_n),
    .press (w_press)
  );

  // Main game FSM. It steps the lives, time, death and flash counters together.
  // respawn can only fire when it was low on the previous cycle, so it never
  // stays high for two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_move_en   <= 1'b0;
      r_respawn   <= 1'b0;
      r_lives     <= 2'd0;
      r_time      <= '0;
      r_flash     <= 1'b0;
      r_frame_cnt <= '0;
      r_dead_cnt  <= '0;
      r_flash_cnt <= '0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_state     <= PLAY;
            r_move_en   <= 1'b1;
            r_respawn   <= ~r_respawn;
            r_lives     <= c_LIVES;
            r_time      <= '0;
            r_frame_cnt <= '0;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (hit) begin
              r_move_en <= 1'b0;
              if (r_lives <= 2'd1) begin
                r_lives <= 2'd0;
                r_state <= OVER;
              end else begin
                r_lives     <= r_lives - 2'd1;
                r_state     <= DEAD;
                r_respawn   <= ~r_respawn;
                r_dead_cnt  <= '0;
                r_flash_cnt <= '0;
                r_flash     <= 1'b1;
              end
            end else if (goal) begin
              r_state   <= WIN;
              r_move_en <= 1'b0;
            end else if (r_frame_cnt == c_FRAME_LAST) begin
              r_frame_cnt <= '0;
              if (r_time != c_TIME_MAX) r_time <= r_time + 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        DEAD: begin
          if (frame_tick) begin
            if (r_dead_cnt == c_DEAD_LAST) begin
              r_state    <= PLAY;
              r_move_en  <= 1'b1;
              r_respawn  <= ~r_respawn;
              r_flash    <= 1'b0;
              r_dead_cnt <= '0;
            end else begin
              r_dead_cnt <= r_dead_cnt + 1'b1;
              if (r_flash_cnt == c_FLASH_LAST) begin
                r_flash_cnt <= '0;
                r_flash     <= ~r_flash;
              end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
              end
            end
          end
        end
        OVER, WIN: begin
          if (w_press) begin
            r_state <= IDLE;
            r_lives <= 2'd0;
            r_time  <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_move_en <= 1'b0;
          r_flash   <= 1'b0;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign move_en  = r_move_en;
  assign respawn  = r_respawn;
  assign lives    = r_lives;
  assign time_sec = r_time;
  assign flash    = r_flash;

endmodule
`default_nettype wire
